// File: rtl/wf_class_arbiter.sv
// wf_class_arbiter: round-robin wavefront picker for one FU class, holding its
// registered choice until accepted and briefly masking the accepted wavefront.
module wf_class_arbiter #(
    parameter int NUM_WF       = 40,
    parameter int WF_ID_LENGTH = 6,
    parameter int MASK_CYCLES  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_WF-1:0]       wf_ready_i,
    input  logic                    issued_valid_i,
    input  logic                    class_select_i,
    input  logic [WF_ID_LENGTH-1:0] issued_wfid_i,
    output logic                    wf_valid_o,
    output logic [WF_ID_LENGTH-1:0] wf_chosen_o,
    output logic                    err_mismatch_o
);
    logic [WF_ID_LENGTH-1:0] last_grant_q, last_grant_d, mask_id_q, mask_id_d;
    logic [WF_ID_LENGTH-1:0] wf_chosen_q, wf_chosen_d, cand;
    logic [1:0]              mask_cnt_q, mask_cnt_d;
    logic                    wf_valid_q, wf_valid_d, err_q, err_d;
    logic                    accept, in_range, upd, hold, cand_valid;
    logic [NUM_WF-1:0]       eff;

    assign accept   = issued_valid_i & class_select_i;
    assign in_range = {1'b0, issued_wfid_i} < (WF_ID_LENGTH+1)'(NUM_WF);
    assign upd      = accept & in_range;

    always_comb begin
        eff = wf_ready_i;
        if (mask_cnt_q != 2'd0) eff[mask_id_q] = 1'b0;
        if (upd) eff[issued_wfid_i] = 1'b0;
    end

    // Scan from lowest to highest priority so the last hit written is the first in rotation.
    always_comb begin
        int start, idx;
        logic [WF_ID_LENGTH-1:0] idx_w;
        start = int'(upd ? issued_wfid_i : last_grant_q) + 1;
        if (start >= NUM_WF) start = 0;
        idx = 0;
        idx_w = '0;
        cand = '0;
        cand_valid = 1'b0;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            idx = start + i;
            if (idx >= NUM_WF) idx = idx - NUM_WF;
            idx_w = WF_ID_LENGTH'(idx);
            if (eff[idx_w]) begin
                cand = idx_w;
                cand_valid = 1'b1;
            end
        end
    end

    assign hold         = wf_valid_q & ~accept & eff[wf_chosen_q];
    assign wf_valid_d   = hold | cand_valid;
    assign wf_chosen_d  = (hold | ~cand_valid) ? wf_chosen_q : cand;
    assign last_grant_d = upd ? issued_wfid_i : last_grant_q;
    assign mask_id_d    = upd ? issued_wfid_i : mask_id_q;
    // The accept cycle is itself the first masked cycle, so the counter covers the rest.
    assign mask_cnt_d   = upd ? 2'(MASK_CYCLES - 1) : (mask_cnt_q != 2'd0 ? mask_cnt_q - 2'd1 : 2'd0);
    assign err_d        = err_q | (accept & (~wf_valid_q | ~in_range | (issued_wfid_i != wf_chosen_q)));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_grant_q <= WF_ID_LENGTH'(NUM_WF - 1);
            mask_id_q    <= '0;
            mask_cnt_q   <= 2'd0;
            wf_valid_q   <= 1'b0;
            wf_chosen_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            mask_id_q    <= mask_id_d;
            mask_cnt_q   <= mask_cnt_d;
            wf_valid_q   <= wf_valid_d;
            wf_chosen_q  <= wf_chosen_d;
            err_q        <= err_d;
        end
    end

    assign wf_valid_o     = wf_valid_q;
    assign wf_chosen_o    = wf_chosen_q;
    assign err_mismatch_o = err_q;
endmodule

// File: tb/tb_wf_class_arbiter.sv
// tb_wf_class_arbiter: directed vectors feed a queue of expected outputs that a
// negedge monitor pops and compares one cycle after each stimulus edge.
module tb_wf_class_arbiter;
    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [39:0] wf_ready_i = '0;
    logic        issued_valid_i = 1'b0;
    logic        class_select_i = 1'b0;
    logic [5:0]  issued_wfid_i = '0;
    logic        wf_valid_o;
    logic [5:0]  wf_chosen_o;
    logic        err_mismatch_o;

    typedef struct {
        int         due;
        logic       v;
        logic [5:0] c;
        logic       e;
        logic       cc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wf_class_arbiter #(.NUM_WF(40), .WF_ID_LENGTH(6), .MASK_CYCLES(2)) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .wf_ready_i(wf_ready_i),
        .issued_valid_i(issued_valid_i),
        .class_select_i(class_select_i),
        .issued_wfid_i(issued_wfid_i),
        .wf_valid_o(wf_valid_o),
        .wf_chosen_o(wf_chosen_o),
        .err_mismatch_o(err_mismatch_o)
    );

    always @(negedge clk) begin : monitor
        exp_t x;
        while (q.size() > 0 && q[0].due <= cyc) begin
            x = q.pop_front();
            vectors++;
            if (x.due != cyc || wf_valid_o !== x.v || err_mismatch_o !== x.e ||
                (x.cc && wf_chosen_o !== x.c)) begin
                errors++;
                $display("FAIL vec%0d cyc%0d: got valid=%b chosen=%0d err=%b, expected valid=%b chosen=%0d err=%b (chosen checked=%b)",
                         vectors, cyc, wf_valid_o, wf_chosen_o, err_mismatch_o, x.v, x.c, x.e, x.cc);
            end
        end
    end

    function automatic logic [39:0] b(input int i);
        logic [39:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic step(input logic r, input logic [39:0] rdy, input logic iv, input logic cs,
                        input logic [5:0] id, input logic ev, input logic [5:0] ec,
                        input logic ee, input logic cc);
        exp_t x;
        rst_i = r;
        wf_ready_i = rdy;
        issued_valid_i = iv;
        class_select_i = cs;
        issued_wfid_i = id;
        x.due = cyc + 1;
        x.v = ev;
        x.c = ec;
        x.e = ee;
        x.cc = cc;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [39:0] rdy, input logic ev, input logic [5:0] ec, input logic ee, input logic cc);
        step(1'b1, rdy, 1'b0, 1'b0, 6'd0, ev, ec, ee, cc);
    endtask

    task automatic acc(input logic [39:0] rdy, input logic [5:0] id, input logic ev, input logic [5:0] ec,
                       input logic ee, input logic cc);
        step(1'b1, rdy, 1'b1, 1'b1, id, ev, ec, ee, cc);
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1);
        idle(b(0), 1'b1, 6'd0, 1'b0, 1'b1);
        acc(b(0), 6'd0, 1'b0, 6'd0, 1'b0, 1'b1);
        idle('0, 1'b0, 6'd0, 1'b0, 1'b0);
        // round robin over 3, 7, 39 with wrap back to 3
        idle(b(3) | b(7) | b(39), 1'b1, 6'd3, 1'b0, 1'b1);
        acc(b(3) | b(7) | b(39), 6'd3, 1'b1, 6'd7, 1'b0, 1'b1);
        acc(b(3) | b(7) | b(39), 6'd7, 1'b1, 6'd39, 1'b0, 1'b1);
        acc(b(3) | b(7) | b(39), 6'd39, 1'b1, 6'd3, 1'b0, 1'b1);
        acc(b(3) | b(7) | b(39), 6'd3, 1'b1, 6'd7, 1'b0, 1'b1);
        idle('0, 1'b0, 6'd0, 1'b0, 1'b0);
        // masking of a lone ready wavefront
        idle(b(5), 1'b1, 6'd5, 1'b0, 1'b1);
        acc(b(5), 6'd5, 1'b0, 6'd0, 1'b0, 1'b0);
        idle(b(5), 1'b0, 6'd0, 1'b0, 1'b0);
        idle(b(5), 1'b1, 6'd5, 1'b0, 1'b1);
        step(1'b1, b(5), 1'b1, 1'b0, 6'd5, 1'b1, 6'd5, 1'b0, 1'b1);
        // hold against higher priority, then withdrawal
        acc(b(1) | b(5), 6'd5, 1'b1, 6'd1, 1'b0, 1'b1);
        acc(b(1), 6'd1, 1'b0, 6'd0, 1'b0, 1'b0);
        idle(b(10), 1'b1, 6'd10, 1'b0, 1'b1);
        idle(b(10) | b(2), 1'b1, 6'd10, 1'b0, 1'b1);
        idle(b(10) | b(2), 1'b1, 6'd10, 1'b0, 1'b1);
        idle(b(2), 1'b1, 6'd2, 1'b0, 1'b1);
        idle(b(10), 1'b1, 6'd10, 1'b0, 1'b1);
        // mismatched accept: sticky error, search resumes after 12
        acc(b(10) | b(12) | b(13), 6'd12, 1'b1, 6'd13, 1'b1, 1'b1);
        idle(b(10) | b(13), 1'b1, 6'd13, 1'b1, 1'b1);
        acc(b(10) | b(13), 6'd13, 1'b1, 6'd10, 1'b1, 1'b1);
        // reset during an active mask
        step(1'b0, b(10) | b(13), 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1);
        idle(b(13) | b(20), 1'b1, 6'd13, 1'b0, 1'b1);
        // out-of-range id: error, pointer untouched
        acc(b(13) | b(20), 6'd45, 1'b1, 6'd13, 1'b1, 1'b1);
        idle(b(20), 1'b1, 6'd20, 1'b1, 1'b1);
        // accept while nothing presented
        step(1'b0, '0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1);
        acc('0, 6'd4, 1'b0, 6'd0, 1'b1, 1'b0);
        idle(b(2) | b(4) | b(6), 1'b1, 6'd6, 1'b1, 1'b1);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
